// File: rtl/dma_pkg.sv
// Shared types for the DMA output engine: FSM state encoding and the FIFO entry layout.
package dma_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dma_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } dma_entry_t;

    localparam int unsigned DMA_WORD_BYTES = 4;

endpackage

// File: rtl/dma_fifo.sv
// Circular FIFO of address/data entries with a single push port, head and head+1 read ports.
module dma_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  dma_entry_t               push_entry,
    input  logic                     pop,
    output dma_entry_t               head,
    output logic [31:0]              second_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dma_entry_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_nx;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_ptr_nx   = rd_ptr_q + AW'(1);
    assign head        = mem[rd_ptr_q];
    assign second_addr = mem[rd_ptr_nx].addr;
    assign count       = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nx;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/dma_out_engine.sv
// Buffers CPU DMA writes and re-emits them as contiguous-address bursts with a timeout flush.
// Optional running burst checksum output enabled by defining DMA_CKSUM_EN.
module dma_out_engine
    import dma_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] memAddr,
    input  logic [31:0] memDataOut,
    output logic        nextTransaction,
    output logic        dma_valid,
    input  logic        dma_ready,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_data,
    output logic        dma_last,
    output logic        busy,
    output logic        ovf
`ifdef DMA_CKSUM_EN
    ,
    output logic [31:0] dma_cksum
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C     = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT_C = CW'(BURST_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

    dma_state_t    state_q, state_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          ovf_q, ovf_d;
    logic          last_hold_q, last_hold_d;

    dma_entry_t    head;
    dma_entry_t    push_entry;
    logic [31:0]   second_addr;
    logic [CW-1:0] count;
    logic          push;
    logic          xfer;
    logic          last_raw;

    assign push_entry = '{addr: memAddr, data: memDataOut};

    dma_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (xfer),
        .head        (head),
        .second_addr (second_addr),
        .count       (count)
    );

    // Handshake: a beat moves on dma_valid && dma_ready; while stalled the
    // presented beat (addr, data, last) is held and valid never drops.
    assign nextTransaction = (count < DEPTH_C);
    assign push            = en && nextTransaction;
    assign dma_valid       = (state_q == SEND);
    assign xfer            = dma_valid && dma_ready;
    assign busy            = (count != '0) || dma_valid;
    assign ovf             = ovf_q;

    assign dma_addr = dma_valid ? head.addr : '0;
    assign dma_data = dma_valid ? head.data : '0;

    assign last_raw = (beat_cnt_q == LAST_BEAT_C) || (count == CW'(1))
                   || (second_addr != head.addr + 32'(DMA_WORD_BYTES));
    // A push during a stall could make count>1 or fill the head+1 slot; the hold keeps last asserted.
    assign dma_last = dma_valid && (last_hold_q || last_raw);

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = '0;
        beat_cnt_d  = beat_cnt_q;
        ovf_d       = ovf_q || (en && !nextTransaction);
        last_hold_d = dma_valid && dma_last && !dma_ready;
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (count != '0) begin
                    if ((count >= BURST_C) || (idle_cnt_q >= TIMEOUT_C)) begin
                        state_d = SEND;
                    end else begin
                        // Below TIMEOUT here, so the increment never passes it.
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (dma_last) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idle_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            last_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            ovf_q       <= ovf_d;
            last_hold_q <= last_hold_d;
        end
    end

`ifdef DMA_CKSUM_EN
    logic [31:0] cksum_acc_q, cksum_acc_d;

    // Accumulator holds the sum of beats already sent; the presented beat is added on the output.
    assign dma_cksum = cksum_acc_q + dma_data;

    always_comb begin
        cksum_acc_d = cksum_acc_q;
        if (xfer) begin
            cksum_acc_d = dma_last ? '0 : (cksum_acc_q + dma_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_acc_q <= '0;
        end else begin
            cksum_acc_q <= cksum_acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_dma_out_engine.sv
// Directed bench for dma_out_engine: bursts, timeout flush, discontinuity, backpressure, reset, wrap.
module tb_dma_out_engine;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] memAddr;
  logic [31:0] memDataOut;
  logic        nextTransaction;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [31:0] dma_data;
  logic        dma_last;
  logic        busy;
  logic        ovf;
`ifdef DMA_CKSUM_EN
  logic [31:0] dma_cksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [31:0] sum_model;

  dma_out_engine #(
    .DEPTH     (8),
    .BURST_LEN (4),
    .TIMEOUT   (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .memAddr         (memAddr),
    .memDataOut      (memDataOut),
    .nextTransaction (nextTransaction),
    .dma_valid       (dma_valid),
    .dma_ready       (dma_ready),
    .dma_addr        (dma_addr),
    .dma_data        (dma_data),
    .dma_last        (dma_last),
    .busy            (busy),
    .ovf             (ovf)
`ifdef DMA_CKSUM_EN
    ,
    .dma_cksum       (dma_cksum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    en         = 1'b1;
    memAddr    = a;
    memDataOut = d;
    tick();
    en = 1'b0;
  endtask

  task automatic expect_beat(input logic last, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({last, a, d});
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!dma_valid && k < budget) begin
      tick();
      k++;
    end
    check("valid_seen", 32'(dma_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  // scoreboard: every transferred beat is matched against the expected queue
  always @(negedge clk) begin
    if (!rst_n) begin
      sum_model = '0;
    end else if (dma_valid && dma_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", dma_addr, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_addr", dma_addr, mon_e[63:32]);
        check("beat_data", dma_data, mon_e[31:0]);
        check("beat_last", 32'(dma_last), 32'(mon_e[64]));
`ifdef DMA_CKSUM_EN
        sum_model = sum_model + dma_data;
        if (dma_last) begin
          check("beat_cksum", dma_cksum, sum_model);
          sum_model = '0;
        end
`endif
      end
    end
  end

  initial begin
    int k;
    rst_n      = 1'b0;
    en         = 1'b0;
    memAddr    = '0;
    memDataOut = '0;
    dma_ready  = 1'b0;
    sum_model  = '0;
    repeat (3) tick();

    // reset values
    check("rst_next", 32'(nextTransaction), 32'd1);
    check("rst_valid", 32'(dma_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_addr", dma_addr, 32'd0);
    check("rst_data", dma_data, 32'd0);
    check("rst_last", 32'(dma_last), 32'd0);
    rst_n = 1'b1;
    tick();

    // full burst, streamed without bubbles
    dma_ready = 1'b1;
    expect_beat(1'b0, 32'h100, 32'd1);
    expect_beat(1'b0, 32'h104, 32'd2);
    expect_beat(1'b0, 32'h108, 32'd3);
    expect_beat(1'b1, 32'h10C, 32'd4);
    push(32'h100, 32'd1);
    push(32'h104, 32'd2);
    push(32'h108, 32'd3);
    push(32'h10C, 32'd4);
    check("fb_idle_after_push", 32'(dma_valid), 32'd0);
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      check("fb_stream_valid", 32'(dma_valid), 32'd1);
      tick();
    end
    check("fb_gap", 32'(dma_valid), 32'd0);
    wait_drain(50);

    // timeout flush of a single word
    expect_beat(1'b1, 32'h200, 32'hAA);
    push(32'h200, 32'hAA);
    check("to_busy", 32'(busy), 32'd1);
    k = 1;
    while (!dma_valid && k < 40) begin
      tick();
      k++;
    end
    check("to_latency", 32'(k), 32'd18);
    check("to_last", 32'(dma_last), 32'd1);
    tick();
    check("to_busy_fall", 32'(busy), 32'd0);
    wait_drain(20);

    // address discontinuity splits into two bursts
    expect_beat(1'b0, 32'h00, 32'h10);
    expect_beat(1'b1, 32'h04, 32'h11);
    expect_beat(1'b0, 32'h40, 32'h12);
    expect_beat(1'b1, 32'h44, 32'h13);
    push(32'h00, 32'h10);
    push(32'h04, 32'h11);
    push(32'h40, 32'h12);
    push(32'h44, 32'h13);
    wait_drain(100);

    // backpressure and overflow
    dma_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("bp_next", 32'(nextTransaction), (i < 8) ? 32'd1 : 32'd0);
      if (dma_valid) begin
        check("bp_hold_data", dma_data, 32'h1000);
      end
      push(32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
    end
    check("bp_ovf", 32'(ovf), 32'd1);
    check("bp_next_full", 32'(nextTransaction), 32'd0);
    check("bp_valid", 32'(dma_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_addr", dma_addr, 32'h300);
      check("bp_hold_data2", dma_data, 32'h1000);
      check("bp_hold_last", 32'(dma_last), 32'd0);
      check("bp_ovf_sticky", 32'(ovf), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      expect_beat((i == 3) || (i == 7), 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
    end
    dma_ready = 1'b1;
    wait_drain(60);
    check("bp_ovf_after", 32'(ovf), 32'd1);
    check("bp_next_after", 32'(nextTransaction), 32'd1);

    // reset during the second beat of a burst
    expect_beat(1'b0, 32'h400, 32'h40);
    push(32'h400, 32'h40);
    push(32'h404, 32'h41);
    push(32'h408, 32'h42);
    push(32'h40C, 32'h43);
    wait_valid(10);
    tick();
    check("mr_second_beat", dma_addr, 32'h404);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(dma_valid), 32'd0);
    check("mr_next", 32'(nextTransaction), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ovf", 32'(ovf), 32'd0);
    check("mr_addr", dma_addr, 32'd0);
    check("mr_data", dma_data, 32'd0);
    check("mr_last", 32'(dma_last), 32'd0);
`ifdef DMA_CKSUM_EN
    check("mr_cksum", dma_cksum, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_exp_done", 32'(exp_q.size()), 32'd0);
    expect_beat(1'b0, 32'h500, 32'h50);
    expect_beat(1'b0, 32'h504, 32'h51);
    expect_beat(1'b0, 32'h508, 32'h52);
    expect_beat(1'b1, 32'h50C, 32'h53);
    push(32'h500, 32'h50);
    push(32'h504, 32'h51);
    push(32'h508, 32'h52);
    push(32'h50C, 32'h53);
    wait_drain(50);

    // address wrap counts as contiguous
    expect_beat(1'b0, 32'hFFFF_FFF8, 32'h70);
    expect_beat(1'b0, 32'hFFFF_FFFC, 32'h71);
    expect_beat(1'b0, 32'h0000_0000, 32'h72);
    expect_beat(1'b1, 32'h0000_0004, 32'h73);
    push(32'hFFFF_FFF8, 32'h70);
    push(32'hFFFF_FFFC, 32'h71);
    push(32'h0000_0000, 32'h72);
    push(32'h0000_0004, 32'h73);
    wait_drain(50);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_ovf", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
